zpu_sd_sched: RTL and testbench
===============================

ZPU_SD_SCHED -- requirements
Module: zpu_sd_sched

Interface
REQ-001 CLK  in  1  system clock; all logic is rising-edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 zpu_data  in  32  ZPU output word; LBA value, or write byte in [7:0].
REQ-004 zpu_lba_sel  in  1  1: data strobe targets LBA register; 0: targets buffer.
REQ-005 zpu_data_wr  in  1  ZPU data-write strobe, level, edge-detected.
REQ-006 zpu_data_rd  in  1  ZPU data-read strobe, level, edge-detected.
REQ-007 zpu_io_wr  in  1  buffer pointer clear, level.
REQ-008 zpu_block_rd / zpu_block_wr  in  1 each  block command requests, level, edge-detected.
REQ-009 sd_lba  out  32  sector address to hps_io.
REQ-010 sd_rd / sd_wr  out  1 each  sector requests to hps_io.
REQ-011 sd_ack  in  1  hps_io transfer acknowledge.
REQ-012 buf_addr  out  9  ZPU-side sector buffer address.
REQ-013 buf_wr  out  1  ZPU-side buffer write enable.
REQ-014 buf_din  out  8  ZPU-side buffer write data.
REQ-015 io_done  out  1  1 = idle/complete, 0 = block operation in progress.
REQ-016 io_err  out  1  last operation timed out.
REQ-017 busy  out  1  state != IDLE.

Function
REQ-018 States: IDLE, REQ (sd_rd or sd_wr high, awaiting sd_ack=1), XFER (sd_ack=1, awaiting fall), DONE (one cycle), then IDLE.
REQ-019 Rising edges are detected against a one-cycle registered copy; the action occurs in the cycle after the edge is seen.
REQ-020 zpu_block_rd rise in IDLE: sd_rd=1, io_done=0, io_err=0, enter REQ next cycle.
REQ-021 zpu_block_wr rise in IDLE: sd_wr=1, io_done=0, io_err=0, enter REQ.
REQ-022 Simultaneous block_rd and block_wr rises: read wins; the write is discarded.
REQ-023 Block command edges outside IDLE are ignored, not queued.
REQ-024 REQ with sd_ack=1: sd_rd and sd_wr go 0 the same cycle; enter XFER.
REQ-025 XFER with sd_ack=0: enter DONE; DONE sets io_done=1 and returns to IDLE.
REQ-026 zpu_data_wr rise with zpu_lba_sel=1: sd_lba <= zpu_data; the LBA is accepted in any state and is not used until the next command.
REQ-027 zpu_data_wr rise with zpu_lba_sel=0: buf_din <= zpu_data[7:0]; buf_wr high exactly one cycle; buf_addr increments in the cycle after buf_wr.
REQ-028 zpu_data_rd fall: buf_addr increments by 1.
REQ-029 buf_addr is 9-bit modulo; 511+1 wraps to 0.
REQ-030 zpu_io_wr=1: buf_addr <= 0, overriding any same-cycle increment; a pending buf_wr still fires at the cleared address.
REQ-031 Buffer accesses are permitted in all states; the ZPU firmware avoids touching the buffer while busy.

Reset
REQ-032 RESET_N=0 asynchronously forces: IDLE; sd_rd=sd_wr=0; buf_wr=0; buf_addr=0; buf_din=0; sd_lba=0; io_done=1; io_err=0; busy=0; edge registers=0.
REQ-033 Reset asserted mid-operation aborts the operation immediately; there is no completion pulse after release.
REQ-034 The first edge after reset release is detected against the reset value 0: a level already high at release counts as a rise.

Configuration
REQ-035 Macro ZPU_SD_TIMEOUT_EN defined: a 24-bit counter clears on entry to REQ and counts in REQ and XFER.
REQ-036 When the counter reaches 0xFFFFFF: sd_rd=sd_wr=0, io_err=1, io_done=1, return to IDLE.
REQ-037 Macro not defined: no counter is built, io_err is tied to 0, and REQ/XFER wait indefinitely.

Verification
REQ-038 LBA write 0x00001234 then block_rd rise, ack high at +3 cycles for 4 cycles -> sd_lba=0x1234; sd_rd high 3 cycles; io_done rises 2 cycles after ack falls.
REQ-039 io_wr pulse, then 3 data_wr strobes 0xA5, 0x5A, 0xFF -> buf_wr pulses at addresses 0, 1, 2 with matching data; final buf_addr=3.
REQ-040 512 data_rd strobes from address 0 -> buf_addr returns to 0.
REQ-041 block_rd and block_wr rise in the same cycle -> only sd_rd asserts; a block_wr rise during XFER is ignored.
REQ-042 With ZPU_SD_TIMEOUT_EN, block_wr with sd_ack held 0 -> after 2^24-1 cycles sd_wr=0, io_err=1, io_done=1; the next block_rd clears io_err.
REQ-043 RESET_N low while in XFER -> all outputs at their REQ-032 values within the same cycle; no io_done edge after release.

Source files
------------

// File: rtl/zpu_sd_sched_if.sv
// ZPU <-> SD sector scheduler signal bundle: ZPU strobes, hps_io sector handshake,
// ZPU-side sector buffer port and status/debug outputs.
interface zpu_sd_sched_if;
    // ZPU strobes are levels; the scheduler acts on their edges. sd_rd/sd_wr are held
    // high until sd_ack is seen high, then dropped; the transfer ends when sd_ack falls.
    logic [31:0] zpu_data;
    logic        zpu_lba_sel;
    logic        zpu_data_wr;
    logic        zpu_data_rd;
    logic        zpu_io_wr;
    logic        zpu_block_rd;
    logic        zpu_block_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  buf_addr;
    logic        buf_wr;
    logic [7:0]  buf_din;
    logic        io_done;
    logic        io_err;
    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  zpu_data, zpu_lba_sel, zpu_data_wr, zpu_data_rd, zpu_io_wr,
               zpu_block_rd, zpu_block_wr, sd_ack,
        output sd_lba, sd_rd, sd_wr, buf_addr, buf_wr, buf_din,
               io_done, io_err, busy, dbg_state
    );

    modport master (
        output zpu_data, zpu_lba_sel, zpu_data_wr, zpu_data_rd, zpu_io_wr,
               zpu_block_rd, zpu_block_wr, sd_ack,
        input  sd_lba, sd_rd, sd_wr, buf_addr, buf_wr, buf_din,
               io_done, io_err, busy, dbg_state
    );
endinterface

// File: rtl/zpu_sd_sched.sv
// Sector request scheduler between ZPU firmware and hps_io, plus buffer pointer logic.
// Optional request watchdog enabled by defining ZPU_SD_TIMEOUT_EN.
module zpu_sd_sched (
    input  logic           CLK,
    input  logic           RESET_N,
    zpu_sd_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, DONE = 2'd3} state_e;

    state_e      state_q, state_d;
    logic [3:0]  edge_q, edge_d;   // {block_wr, block_rd, data_rd, data_wr}
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic        buf_wr_q, buf_wr_d;
    logic        io_done_q, io_done_d;
    logic [8:0]  buf_addr_q, buf_addr_d;
    logic [7:0]  buf_din_q, buf_din_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        data_wr_rise, data_rd_fall, block_rd_rise, block_wr_rise;
`ifdef ZPU_SD_TIMEOUT_EN
    logic        io_err_q, io_err_d;
    logic [23:0] tmo_q, tmo_d;
`endif

    assign data_wr_rise  = bus.zpu_data_wr  & ~edge_q[0];
    assign data_rd_fall  = ~bus.zpu_data_rd & edge_q[1];
    assign block_rd_rise = bus.zpu_block_rd & ~edge_q[2];
    assign block_wr_rise = bus.zpu_block_wr & ~edge_q[3];

    always_comb begin
        state_d    = state_q;
        edge_d     = {bus.zpu_block_wr, bus.zpu_block_rd, bus.zpu_data_rd, bus.zpu_data_wr};
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        buf_wr_d   = 1'b0;
        io_done_d  = io_done_q;
        buf_din_d  = buf_din_q;
        sd_lba_d   = sd_lba_q;
`ifdef ZPU_SD_TIMEOUT_EN
        io_err_d   = io_err_q;
        tmo_d      = tmo_q;
`endif

        if (data_wr_rise && bus.zpu_lba_sel) begin
            sd_lba_d = bus.zpu_data;
        end
        if (data_wr_rise && !bus.zpu_lba_sel) begin
            buf_wr_d  = 1'b1;
            buf_din_d = bus.zpu_data[7:0];
        end

        // Pointer post-increments after a buffer write and after each read strobe.
        buf_addr_d = buf_addr_q + {8'd0, buf_wr_q} + {8'd0, data_rd_fall};
        if (bus.zpu_io_wr) begin
            buf_addr_d = 9'd0;
        end

        case (state_q)
            IDLE: begin
                if (block_rd_rise || block_wr_rise) begin
                    sd_rd_d   = block_rd_rise;
                    sd_wr_d   = ~block_rd_rise;
                    io_done_d = 1'b0;
                    state_d   = REQ;
`ifdef ZPU_SD_TIMEOUT_EN
                    io_err_d  = 1'b0;
                    tmo_d     = 24'd0;
`endif
                end
            end
            REQ: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                io_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef ZPU_SD_TIMEOUT_EN
        // Watchdog overrides the handshake once the count saturates.
        if (state_q == REQ || state_q == XFER) begin
            if (tmo_q == 24'hFF_FFFF) begin
                sd_rd_d   = 1'b0;
                sd_wr_d   = 1'b0;
                io_err_d  = 1'b1;
                io_done_d = 1'b1;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            edge_q     <= 4'd0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            buf_wr_q   <= 1'b0;
            io_done_q  <= 1'b1;
            buf_addr_q <= 9'd0;
            buf_din_q  <= 8'd0;
            sd_lba_q   <= 32'd0;
`ifdef ZPU_SD_TIMEOUT_EN
            io_err_q   <= 1'b0;
            tmo_q      <= 24'd0;
`endif
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            buf_wr_q   <= buf_wr_d;
            io_done_q  <= io_done_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
            sd_lba_q   <= sd_lba_d;
`ifdef ZPU_SD_TIMEOUT_EN
            io_err_q   <= io_err_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.sd_lba    = sd_lba_q;
    assign bus.sd_rd     = sd_rd_q;
    assign bus.sd_wr     = sd_wr_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wr    = buf_wr_q;
    assign bus.buf_din   = buf_din_q;
    assign bus.io_done   = io_done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dbg_state = state_q;
`ifdef ZPU_SD_TIMEOUT_EN
    assign bus.io_err    = io_err_q;
`else
    assign bus.io_err    = 1'b0;
`endif
endmodule

// File: tb/tb_zpu_sd_sched.sv
// Directed testbench for zpu_sd_sched: command handshake, LBA/buffer path, pointer wrap, reset abort.
module tb_zpu_sd_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    zpu_sd_sched_if bus ();

    zpu_sd_sched dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(bus.dbg_state), 32'd0);
        check({tag, "_sd_rd"},  32'(bus.sd_rd),     32'd0);
        check({tag, "_sd_wr"},  32'(bus.sd_wr),     32'd0);
        check({tag, "_buf_wr"}, 32'(bus.buf_wr),    32'd0);
        check({tag, "_addr"},   32'(bus.buf_addr),  32'd0);
        check({tag, "_din"},    32'(bus.buf_din),   32'd0);
        check({tag, "_lba"},    bus.sd_lba,         32'd0);
        check({tag, "_done"},   32'(bus.io_done),   32'd1);
        check({tag, "_err"},    32'(bus.io_err),    32'd0);
        check({tag, "_busy"},   32'(bus.busy),      32'd0);
    endtask

    initial begin
        int rd_cnt;
        int done_at;
        int bad;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hFF;

        rst_n            = 1'b0;
        bus.zpu_data     = 32'd0;
        bus.zpu_lba_sel  = 1'b0;
        bus.zpu_data_wr  = 1'b0;
        bus.zpu_data_rd  = 1'b0;
        bus.zpu_io_wr    = 1'b0;
        bus.zpu_block_rd = 1'b0;
        bus.zpu_block_wr = 1'b0;
        bus.sd_ack       = 1'b0;
        tick(); tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // LBA load then read command with ack high for 4 cycles
        bus.zpu_data = 32'h0000_1234; bus.zpu_lba_sel = 1'b1; bus.zpu_data_wr = 1'b1;
        tick();
        check("lba_load", bus.sd_lba, 32'h0000_1234);
        check("lba_no_bufwr", 32'(bus.buf_wr), 32'd0);
        bus.zpu_data_wr = 1'b0; bus.zpu_lba_sel = 1'b0;
        tick();
        bus.zpu_block_rd = 1'b1;
        tick();
        bus.zpu_block_rd = 1'b0;
        check("rd_start_done", 32'(bus.io_done), 32'd0);
        check("rd_start_busy", 32'(bus.busy), 32'd1);
        check("rd_start_state", 32'(bus.dbg_state), 32'd1);
        rd_cnt = 0; done_at = -1;
        for (int c = 0; c < 12; c++) begin
            if (bus.sd_rd) rd_cnt++;
            if (bus.io_done && done_at < 0) done_at = c;
            if (c == 4) check("rd_xfer_state", 32'(bus.dbg_state), 32'd2);
            if (c == 7) check("rd_done_state", 32'(bus.dbg_state), 32'd3);
            bus.sd_ack = (c >= 2 && c <= 5);
            tick();
        end
        check("rd_sd_rd_cycles", 32'(rd_cnt), 32'd3);
        check("rd_done_at", 32'(done_at), 32'd8);
        check("rd_sd_wr", 32'(bus.sd_wr), 32'd0);
        check("rd_err", 32'(bus.io_err), 32'd0);

        // Pointer clear then three buffer writes
        bus.zpu_io_wr = 1'b1;
        tick();
        bus.zpu_io_wr = 1'b0;
        check("clr_addr", 32'(bus.buf_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.zpu_data = {24'hABCDEF, bytes[i]}; bus.zpu_data_wr = 1'b1;
            tick();
            check($sformatf("wr%0d_pulse", i), 32'(bus.buf_wr), 32'd1);
            check($sformatf("wr%0d_addr", i), 32'(bus.buf_addr), 32'(i));
            check($sformatf("wr%0d_din", i), 32'(bus.buf_din), 32'(bytes[i]));
            bus.zpu_data_wr = 1'b0;
            tick();
            check($sformatf("wr%0d_one_cycle", i), 32'(bus.buf_wr), 32'd0);
        end
        check("wr_final_addr", 32'(bus.buf_addr), 32'd3);
        check("wr_lba_kept", bus.sd_lba, 32'h0000_1234);

        // 512 read strobes wrap the pointer
        bus.zpu_io_wr = 1'b1;
        tick();
        bus.zpu_io_wr = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            bus.zpu_data_rd = 1'b1;
            tick();
            bus.zpu_data_rd = 1'b0;
            tick();
            if (i == 1)   check("rd1_addr", 32'(bus.buf_addr), 32'd1);
            if (i == 511) check("rd511_addr", 32'(bus.buf_addr), 32'd511);
        end
        check("rd512_wrap", 32'(bus.buf_addr), 32'd0);

        // io_wr coinciding with a data write: write lands at address 0
        bus.zpu_data_rd = 1'b1; tick(); bus.zpu_data_rd = 1'b0; tick();
        bus.zpu_data_rd = 1'b1; tick(); bus.zpu_data_rd = 1'b0; tick();
        check("pre_clr_addr", 32'(bus.buf_addr), 32'd2);
        bus.zpu_data = 32'h0000_003C; bus.zpu_data_wr = 1'b1; bus.zpu_io_wr = 1'b1;
        tick();
        bus.zpu_io_wr = 1'b0; bus.zpu_data_wr = 1'b0;
        check("clr_wr_pulse", 32'(bus.buf_wr), 32'd1);
        check("clr_wr_addr", 32'(bus.buf_addr), 32'd0);
        check("clr_wr_din", 32'(bus.buf_din), 32'h3C);
        tick();
        check("clr_wr_post", 32'(bus.buf_addr), 32'd1);

        // Simultaneous rd/wr: read wins; write edge during XFER ignored
        bus.zpu_block_rd = 1'b1; bus.zpu_block_wr = 1'b1;
        tick();
        bus.zpu_block_rd = 1'b0; bus.zpu_block_wr = 1'b0;
        check("both_sd_rd", 32'(bus.sd_rd), 32'd1);
        check("both_sd_wr", 32'(bus.sd_wr), 32'd0);
        bus.sd_ack = 1'b1;
        tick();
        check("both_xfer", 32'(bus.dbg_state), 32'd2);
        bus.zpu_block_wr = 1'b1;
        tick();
        check("xfer_wr_ignored", 32'(bus.sd_wr), 32'd0);
        bus.zpu_block_wr = 1'b0;
        bus.sd_ack = 1'b0;
        tick(); tick();
        check("both_done", 32'(bus.io_done), 32'd1);
        tick(); tick();
        check("no_queued_wr", 32'(bus.sd_wr), 32'd0);
        check("no_queued_busy", 32'(bus.busy), 32'd0);

        // Write command from IDLE, then reset while in XFER
        bus.zpu_data = 32'h0000_0077; bus.zpu_lba_sel = 1'b1; bus.zpu_data_wr = 1'b1;
        tick();
        bus.zpu_data_wr = 1'b0; bus.zpu_lba_sel = 1'b0;
        bus.zpu_block_wr = 1'b1;
        tick();
        bus.zpu_block_wr = 1'b0;
        check("wr_cmd_sd_wr", 32'(bus.sd_wr), 32'd1);
        check("wr_cmd_sd_rd", 32'(bus.sd_rd), 32'd0);
        check("wr_cmd_lba", bus.sd_lba, 32'h77);
        bus.sd_ack = 1'b1;
        tick();
        check("wr_cmd_ack_drop", 32'(bus.sd_wr), 32'd0);
        check("wr_cmd_xfer", 32'(bus.dbg_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        bus.sd_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!bus.io_done || bus.busy) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        // Level already high at reset release counts as a rise
        rst_n = 1'b0;
        bus.zpu_block_rd = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("release_rise", 32'(bus.sd_rd), 32'd1);
        bus.zpu_block_rd = 1'b0;
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick(); tick();
        check("release_done", 32'(bus.io_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
